// File: rtl/fpu_mul_seq_if.sv
// fpu_mul_seq_if: enable/ready handshake bundle between a solver FSM (master) and the multiplier (slave).
interface fpu_mul_seq_if;
   logic        rst;
   logic        enable;
   logic [1:0]  rmode;
   logic [2:0]  fpu_op;
   logic [63:0] opa;
   logic [63:0] opb;
   logic [63:0] out;
   logic        ready;
   logic        overflow;
   logic        underflow;
   logic        inexact;
   logic        invalid;
   logic        exception;
   modport master (
      output rst, enable, rmode, fpu_op, opa, opb,
      input  out, ready, overflow, underflow, inexact, invalid, exception
   );
   modport slave (
      input  rst, enable, rmode, fpu_op, opa, opb,
      output out, ready, overflow, underflow, inexact, invalid, exception
   );
endinterface

// File: rtl/fpu_mul_seq.sv
// fpu_mul_seq: fixed-latency binary64 multiplier, shift-add significand, BITS_PER_CYCLE bits per MULT cycle.
module fpu_mul_seq #(
   parameter int         BITS_PER_CYCLE = 1,
   parameter logic [2:0] OP_CODE        = 3'd2
) (
   input logic          clk,
   input logic          reset_n,
   fpu_mul_seq_if.slave bus
);
   localparam int K  = 54 / BITS_PER_CYCLE;
   localparam int CW = $clog2(K + 1);
   typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_MULT, S_NORM, S_ROUND, S_DONE} state_t;
   state_t             r_state, w_next;
   logic [CW-1:0]      r_cnt;
   logic [63:0]        r_opa, r_opb;
   logic [2:0]         r_op;
   logic [1:0]         r_rmode;
   logic               r_sign, r_special, r_spec_inv;
   logic [63:0]        r_spec_val;
   logic signed [12:0] r_exp;
   logic [105:0]       r_mc, r_acc;
   logic [53:0]        r_mb;
   logic [52:0]        r_man;
   logic               r_g, r_s;
   logic [63:0]        r_out;
   logic               r_ready, r_ov, r_un, r_ix, r_inv;
   logic [10:0]        w_ea, w_eb;
   logic [51:0]        w_fa, w_fb;
   logic               w_za, w_zb, w_infa, w_infb, w_nana, w_nanb, w_inv, w_special;
   logic [63:0]        w_spec_val;
   logic [105:0]       w_pp;
   logic [52:0]        w_nman;
   logic               w_ng, w_ns;
   logic signed [12:0] w_nexp;
   logic               w_inc, w_rx, w_under, w_over, w_ovinf;
   logic [53:0]        w_rsum;
   logic signed [12:0] w_rexp;
   logic [51:0]        w_rfrac;
   logic [63:0]        w_ov_val;
   assign w_ea       = r_opa[62:52];
   assign w_eb       = r_opb[62:52];
   assign w_fa       = r_opa[51:0];
   assign w_fb       = r_opb[51:0];
   assign w_za       = w_ea == 11'd0;
   assign w_zb       = w_eb == 11'd0;
   assign w_infa     = (w_ea == 11'h7FF) && (w_fa == 52'd0);
   assign w_infb     = (w_eb == 11'h7FF) && (w_fb == 52'd0);
   assign w_nana     = (w_ea == 11'h7FF) && (w_fa != 52'd0);
   assign w_nanb     = (w_eb == 11'h7FF) && (w_fb != 52'd0);
   assign w_inv      = w_nana | w_nanb | (w_infa & w_zb) | (w_za & w_infb) | (r_op != OP_CODE);
   assign w_special  = w_inv | w_infa | w_infb | w_za | w_zb;
   assign w_spec_val = w_inv ? 64'h7FF8000000000000 :
                       (w_infa | w_infb) ? {r_opa[63] ^ r_opb[63], 11'h7FF, 52'd0} :
                       {r_opa[63] ^ r_opb[63], 63'd0};
   assign w_pp       = r_mc * 106'(r_mb[BITS_PER_CYCLE-1:0]);
   // Product of two [1,2) significands lies in [1,4): bit 105 selects a one-place normalising shift.
   assign w_nman     = r_acc[105] ? r_acc[105:53] : r_acc[104:52];
   assign w_ng       = r_acc[105] ? r_acc[52] : r_acc[51];
   assign w_ns       = r_acc[105] ? |r_acc[51:0] : |r_acc[50:0];
   assign w_nexp     = r_exp + (r_acc[105] ? 13'sd1 : 13'sd0);
   assign w_rx       = r_g | r_s;
   assign w_inc      = (r_rmode == 2'd0) ? (r_g & (r_s | r_man[0])) :
                       (r_rmode == 2'd2) ? (~r_sign & w_rx) :
                       (r_rmode == 2'd3) ? (r_sign & w_rx) : 1'b0;
   assign w_rsum     = {1'b0, r_man} + {53'd0, w_inc};
   assign w_rexp     = r_exp + (w_rsum[53] ? 13'sd1 : 13'sd0);
   assign w_rfrac    = w_rsum[53] ? w_rsum[52:1] : w_rsum[51:0];
   assign w_under    = r_exp < 13'sd1;
   assign w_over     = w_rexp > 13'sd2046;
   assign w_ovinf    = (r_rmode == 2'd0) | ((r_rmode == 2'd2) & ~r_sign) | ((r_rmode == 2'd3) & r_sign);
   assign w_ov_val   = w_ovinf ? {r_sign, 11'h7FF, 52'd0} : {r_sign, 11'h7FE, {52{1'b1}}};
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   w_next = bus.enable ? S_UNPACK : S_IDLE;
         S_UNPACK: w_next = S_MULT;
         S_MULT:   w_next = (r_cnt == CW'(K - 1)) ? S_NORM : S_MULT;
         S_NORM:   w_next = S_ROUND;
         S_ROUND:  w_next = S_DONE;
         default:  w_next = r_state;
      endcase
      if (bus.rst) w_next = S_IDLE;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
         r_opa <= '0;
         r_opb <= '0;
         r_op <= '0;
         r_rmode <= '0;
         r_sign <= 1'b0;
         r_special <= 1'b0;
         r_spec_inv <= 1'b0;
         r_spec_val <= '0;
         r_exp <= '0;
         r_mc <= '0;
         r_acc <= '0;
         r_mb <= '0;
         r_man <= '0;
         r_g <= 1'b0;
         r_s <= 1'b0;
         r_out <= '0;
         r_ready <= 1'b0;
         r_ov <= 1'b0;
         r_un <= 1'b0;
         r_ix <= 1'b0;
         r_inv <= 1'b0;
      end else if (bus.rst) begin
         r_out <= '0;
         r_ready <= 1'b0;
         r_ov <= 1'b0;
         r_un <= 1'b0;
         r_ix <= 1'b0;
         r_inv <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (bus.enable) begin
               r_opa <= bus.opa;
               r_opb <= bus.opb;
               r_op <= bus.fpu_op;
               r_rmode <= bus.rmode;
            end
            S_UNPACK: begin
               r_sign <= r_opa[63] ^ r_opb[63];
               r_special <= w_special;
               r_spec_inv <= w_inv;
               r_spec_val <= w_spec_val;
               r_exp <= $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - 13'sd1023;
               r_mc <= {53'd0, 1'b1, w_fa};
               r_mb <= {2'b01, w_fb};
               r_acc <= '0;
               r_cnt <= '0;
            end
            S_MULT: begin
               r_acc <= r_acc + w_pp;
               r_mc <= r_mc << BITS_PER_CYCLE;
               r_mb <= r_mb >> BITS_PER_CYCLE;
               r_cnt <= r_cnt + 1'b1;
            end
            S_NORM: begin
               r_man <= w_nman;
               r_g <= w_ng;
               r_s <= w_ns;
               r_exp <= w_nexp;
            end
            S_ROUND: begin
               // Specials were resolved at unpack but still ride the full pipeline to keep latency fixed.
               r_out <= r_special ? r_spec_val : w_under ? {r_sign, 63'd0} :
                        w_over ? w_ov_val : {r_sign, w_rexp[10:0], w_rfrac};
               r_inv <= r_special & r_spec_inv;
               r_un <= ~r_special & w_under;
               r_ov <= ~r_special & ~w_under & w_over;
               r_ix <= ~r_special & (w_under | w_over | w_rx);
               r_ready <= 1'b1;
            end
            default: ;
         endcase
      end
   end
   assign bus.out       = r_out;
   assign bus.ready     = r_ready;
   assign bus.overflow  = r_ov;
   assign bus.underflow = r_un;
   assign bus.inexact   = r_ix;
   assign bus.invalid   = r_inv;
   assign bus.exception = r_ov | r_un | r_inv;
endmodule
